// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSR storage, Zicsr read/modify/write, trap entry and MRET.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_unit #(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic            sys_clk,
  input  logic            sys_reset,
  input  logic            instr_valid_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] rs_data_i,
  input  logic            retire_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_val_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] csr_rd_data_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] trap_vector_o,
  output logic [XLEN-1:0] epc_o,
  output logic            irq_en_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1_field;
  logic [11:0] addr;

  assign opcode    = instr_i[6:0];
  assign funct3    = instr_i[14:12];
  assign rs1_field = instr_i[19:15];
  assign addr      = instr_i[31:20];

  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;
`endif

  logic        is_csr, wants_write, implemented, illegal_raw, do_write;
  logic [31:0] old_val, src, wdata;

  // Decode the instruction class and whether it intends to write
  always_comb begin
    is_csr = (opcode == 7'b1110011) && (funct3 != 3'b000) && (funct3 != 3'b100);
    // Set/clear forms with rs1/zimm == 0 are pure reads
    wants_write = (funct3[1:0] == 2'b01) || (rs1_field != 5'd0);
  end

  // Read mux over the CSR map; flags unimplemented addresses
  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    case (addr)
      12'h300: old_val = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
      12'h304: old_val = mie_q;
      12'h305: old_val = {mtvec_q[31:2], 2'b00};
      12'h340: old_val = mscratch_q;
      12'h341: old_val = {mepc_q[31:2], 2'b00};
      12'h342: old_val = mcause_q;
      12'h343: old_val = mtval_q;
      12'hF14: old_val = HART_ID;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: old_val = mcycle_q[31:0];
      12'hB80, 12'hC80: old_val = mcycle_q[63:32];
      12'hB02, 12'hC02: old_val = minstret_q[31:0];
      12'hB82, 12'hC82: old_val = minstret_q[63:32];
`endif
      default: implemented = 1'b0;
    endcase
  end

  // New-value computation and access checking
  always_comb begin
    src = funct3[2] ? {27'd0, rs1_field} : rs_data_i;
    case (funct3[1:0])
      2'b10:   wdata = old_val | src;
      2'b11:   wdata = old_val & ~src;
      default: wdata = src;
    endcase
    illegal_raw   = is_csr && (!implemented || (wants_write && (addr[11:10] == 2'b11)));
    illegal_o     = instr_valid_i && illegal_raw;
    csr_rd_data_o = (is_csr && !illegal_raw) ? old_val : '0;
    // Trap and MRET take priority and drop the CSR write entirely
    do_write      = instr_valid_i && is_csr && wants_write && !illegal_raw && !trap_i && !mret_i;
  end

  // Architectural CSR state: trap > mret > CSR write
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RESET;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else if (trap_i) begin
      mepc_q       <= {trap_pc_i[31:2], 2'b00};
      mcause_q     <= trap_cause_i;
      mtval_q      <= trap_val_i;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (do_write) begin
      case (addr)
        12'h300: begin
          mstatus_mie  <= wdata[3];
          mstatus_mpie <= wdata[7];
        end
        12'h304: mie_q      <= wdata & 32'h0000_0888;
        12'h305: mtvec_q    <= {wdata[31:2], 2'b00};
        12'h340: mscratch_q <= wdata;
        12'h341: mepc_q     <= {wdata[31:2], 2'b00};
        12'h342: mcause_q   <= wdata;
        12'h343: mtval_q    <= wdata;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // 64-bit counters; a write to either half replaces that cycle's increment
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (do_write && addr == 12'hB00)      mcycle_q <= {mcycle_q[63:32], wdata};
      else if (do_write && addr == 12'hB80) mcycle_q <= {wdata, mcycle_q[31:0]};
      else                                  mcycle_q <= mcycle_q + 64'd1;

      if (do_write && addr == 12'hB02)      minstret_q <= {minstret_q[63:32], wdata};
      else if (do_write && addr == 12'hB82) minstret_q <= {wdata, minstret_q[31:0]};
      else if (retire_i)                    minstret_q <= minstret_q + 64'd1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire_i;
`endif

  // Status outputs straight from storage
  always_comb begin
    trap_vector_o = {mtvec_q[31:2], 2'b00};
    epc_o         = {mepc_q[31:2], 2'b00};
    irq_en_o      = mstatus_mie;
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit (counter checks follow CSR_COUNTERS_EN).
module tb_csr_unit;
  localparam logic [31:0] MtvecRst = 32'h0000_1000;
  localparam logic [31:0] HartId   = 32'd5;

  logic        sys_clk = 1'b0;
  logic        sys_reset;
  logic        instr_valid_i;
  logic [31:0] instr_i, rs_data_i;
  logic        retire_i, trap_i, mret_i;
  logic [31:0] trap_cause_i, trap_pc_i, trap_val_i;
  logic [31:0] csr_rd_data_o, trap_vector_o, epc_o;
  logic        illegal_o, irq_en_o;

  int checks = 0;
  int failures = 0;

  csr_unit #(.XLEN(32), .MTVEC_RESET(MtvecRst), .HART_ID(HartId)) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .instr_valid_i(instr_valid_i),
    .instr_i(instr_i), .rs_data_i(rs_data_i), .retire_i(retire_i), .trap_i(trap_i),
    .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i), .trap_val_i(trap_val_i),
    .mret_i(mret_i), .csr_rd_data_o(csr_rd_data_o), .illegal_o(illegal_o),
    .trap_vector_o(trap_vector_o), .epc_o(epc_o), .irq_en_o(irq_en_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] csr(input logic [11:0] a, input logic [4:0] rs1,
                                      input logic [2:0] f3);
    return {a, rs1, f3, 5'd1, 7'b1110011};
  endfunction

  // Commit on the next edge, then settle just after it
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Apply a valid CSR instruction and let combinational outputs settle
  task automatic issue(input logic [31:0] ins, input logic [31:0] rs);
    instr_valid_i = 1'b1;
    instr_i       = ins;
    rs_data_i     = rs;
    #1;
  endtask

  initial begin
    sys_reset = 1'b1; instr_valid_i = 1'b0; instr_i = '0; rs_data_i = '0;
    retire_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0;
    trap_cause_i = '0; trap_pc_i = '0; trap_val_i = '0;
    issue(32'h305020F3, 32'h0);
    check("rst_vec", trap_vector_o, MtvecRst);
    check("rst_epc", epc_o, 32'h0);
    check("rst_irq", {31'd0, irq_en_o}, 32'h0);
    check("rst_rd_mtvec", csr_rd_data_o, MtvecRst);
    step();
    sys_reset = 1'b0;
    #1;
    check("mtvec_read", csr_rd_data_o, MtvecRst);
    check("mtvec_ill", {31'd0, illegal_o}, 32'h0);
    step();
    check("mtvec_nowrite", trap_vector_o, MtvecRst);

    // mscratch RW then RC
    issue(csr(12'h340, 5'd2, 3'b001), 32'hDEAD_BEEF);
    check("mscr_old", csr_rd_data_o, 32'h0);
    step();
    issue(csr(12'h340, 5'd3, 3'b011), 32'h0000_FFFF);
    check("mscr_rc_old", csr_rd_data_o, 32'hDEAD_BEEF);
    step();
    issue(csr(12'h340, 5'd0, 3'b010), 32'h0);
    check("mscr_after_rc", csr_rd_data_o, 32'hDEAD_0000);
    // Invalid instruction must not write
    instr_valid_i = 1'b0; instr_i = csr(12'h340, 5'd2, 3'b001); rs_data_i = 32'h1;
    step();
    issue(csr(12'h340, 5'd0, 3'b010), 32'h0);
    check("mscr_novalid", csr_rd_data_o, 32'hDEAD_0000);

    // mtvec / mie write masking
    issue(csr(12'h305, 5'd2, 3'b001), 32'h0000_2003);
    step();
    check("mtvec_mask", trap_vector_o, 32'h0000_2000);
    issue(csr(12'h304, 5'd2, 3'b001), 32'hFFFF_FFFF);
    step();
    issue(csr(12'h304, 5'd0, 3'b010), 32'h0);
    check("mie_mask", csr_rd_data_o, 32'h0000_0888);

    // mstatus, trap, mret
    issue(csr(12'h300, 5'd8, 3'b110), 32'h0);
    check("mstatus_old", csr_rd_data_o, 32'h0000_1800);
    step();
    check("irq_set", {31'd0, irq_en_o}, 32'h1);
    instr_valid_i = 1'b0;
    trap_i = 1'b1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h100; trap_val_i = 32'h44;
    step();
    trap_i = 1'b0;
    check("trap_epc", epc_o, 32'h100);
    check("trap_irq", {31'd0, irq_en_o}, 32'h0);
    issue(csr(12'h342, 5'd0, 3'b010), 32'h0);
    check("trap_mcause", csr_rd_data_o, 32'h8000_0007);
    issue(csr(12'h343, 5'd0, 3'b010), 32'h0);
    check("trap_mtval", csr_rd_data_o, 32'h44);
    issue(csr(12'h300, 5'd0, 3'b010), 32'h0);
    check("trap_mstatus", csr_rd_data_o, 32'h0000_1880);
    instr_valid_i = 1'b0;
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    check("mret_irq", {31'd0, irq_en_o}, 32'h1);
    issue(csr(12'h300, 5'd0, 3'b010), 32'h0);
    check("mret_mstatus", csr_rd_data_o, 32'h0000_1888);

    // Trap coincident with a CSR write: write dropped
    issue(csr(12'h341, 5'd2, 3'b001), 32'h55);
    trap_i = 1'b1; trap_cause_i = 32'h2; trap_pc_i = 32'h200;
    step();
    trap_i = 1'b0;
    check("trap_prio_epc", epc_o, 32'h200);

    // Access checks
    issue(csr(12'hF14, 5'd2, 3'b001), 32'h1);
    check("hart_wr_ill", {31'd0, illegal_o}, 32'h1);
    check("hart_wr_rd", csr_rd_data_o, 32'h0);
    issue(csr(12'hF14, 5'd0, 3'b010), 32'h0);
    check("hart_rd", csr_rd_data_o, HartId);
    check("hart_rd_ill", {31'd0, illegal_o}, 32'h0);
    issue(csr(12'h7C0, 5'd0, 3'b010), 32'h0);
    check("unimpl_ill", {31'd0, illegal_o}, 32'h1);
    issue(csr(12'h340, 5'd0, 3'b000), 32'h0);
    check("f3_0_ill", {31'd0, illegal_o}, 32'h0);
    check("f3_0_rd", csr_rd_data_o, 32'h0);
    // Illegal write must commit nothing
    issue(csr(12'h7C0, 5'd2, 3'b001), 32'h1);
    step();
    issue(csr(12'h340, 5'd0, 3'b010), 32'h0);
    check("ill_nocommit", csr_rd_data_o, 32'hDEAD_0000);

`ifdef CSR_COUNTERS_EN
    issue(csr(12'hB00, 5'd2, 3'b001), 32'hFFFF_FFFE);
    step();
    issue(csr(12'hB80, 5'd2, 3'b001), 32'h0);
    step();
    issue(csr(12'hB00, 5'd0, 3'b010), 32'h0);
    check("mcycle_lo_hold", csr_rd_data_o, 32'hFFFF_FFFE);
    step();
    check("mcycle_lo_inc", csr_rd_data_o, 32'hFFFF_FFFF);
    issue(csr(12'hB80, 5'd0, 3'b010), 32'h0);
    check("mcycleh_pre", csr_rd_data_o, 32'h0);
    step();
    check("mcycleh_carry", csr_rd_data_o, 32'h1);
    issue(csr(12'hC00, 5'd0, 3'b010), 32'h0);
    check("cycle_wrap", csr_rd_data_o, 32'h0);
    issue(csr(12'hC00, 5'd2, 3'b001), 32'h1);
    check("cycle_wr_ill", {31'd0, illegal_o}, 32'h1);
    issue(csr(12'hB02, 5'd2, 3'b001), 32'h5);
    retire_i = 1'b1;
    step();
    instr_valid_i = 1'b0;
    step();
    step();
    retire_i = 1'b0;
    issue(csr(12'hC02, 5'd0, 3'b010), 32'h0);
    check("instret", csr_rd_data_o, 32'h7);
`else
    issue(csr(12'hB00, 5'd0, 3'b010), 32'h0);
    check("mcycle_ill", {31'd0, illegal_o}, 32'h1);
    check("mcycle_rd", csr_rd_data_o, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
